// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte requesters.
// Optional WAIT timeout with err output: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_TICKS = 320
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               tx_start,
  output logic [7:0]         tx_din,
  input  logic               tx_done_tick
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  localparam int unsigned PW = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_ack;
  logic               r_busy;
  logic [IDX_W-1:0]   r_grant;
  logic               r_start;
  logic [7:0]         r_din;
  logic [IDX_W-1:0]   r_rr_ptr;

  logic               w_hit;
  logic [IDX_W-1:0]   w_sel;
  logic [PW-1:0]      w_pos;
  logic [7:0]         w_byte;
  logic [IDX_W-1:0]   w_next;
  logic [N_REQ-1:0]   w_onehot;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);
  logic [CW-1:0]      r_cnt;
  logic               r_err;
  assign err = r_err;
`endif

  // First requester at or after rr_ptr, wrapping; w_pos never exceeds 2*N_REQ-2.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_pos = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, r_rr_ptr} + PW'(k);
      if (w_pos >= PW'(N_REQ)) w_pos = w_pos - PW'(N_REQ);
      if (!w_hit && req[w_pos[IDX_W-1:0]]) begin
        w_hit = 1'b1;
        w_sel = w_pos[IDX_W-1:0];
      end
    end
  end

  assign w_byte   = req_data[{w_sel, 3'b000} +: 8];
  assign w_next   = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_grant  <= '0;
      r_start  <= 1'b0;
      r_din    <= '0;
      r_rr_ptr <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_grant <= w_sel;
            r_din   <= w_byte;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tick) begin
            r_start <= 1'b0;
            r_state <= S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_WAIT: begin
          // Done flag spans a whole tick period, so only qualify it with tick.
          if (tick && tx_done_tick) begin
            r_ack    <= w_onehot;
            r_rr_ptr <= w_next;
            r_state  <= S_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (tick) begin
            if (r_cnt == CW'(TIMEOUT_TICKS - 1)) begin
              r_err    <= 1'b1;
              r_rr_ptr <= w_next;
              r_state  <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`endif
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign grant_idx = r_grant;
  assign tx_start  = r_start;
  assign tx_din    = r_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, behavioural uart_tx and a
// round-robin reference model over pending byte queues.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           tick = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_done_tick = 1'b0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [1:0]     grant_idx;
  logic           tx_start;
  logic [7:0]     tx_din;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic           err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_TICKS(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .req_data(req_data),
    .ack(ack), .busy(busy), .grant_idx(grant_idx), .tx_start(tx_start),
    .tx_din(tx_din), .tx_done_tick(tx_done_tick)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .err(err)
`endif
  );

  logic [7:0] lane_q [N][$];
  int         served_idx[$];
  logic [7:0] served_byte[$];
  int         ack_log[$];
  int         exp_idx[$];
  logic [7:0] exp_byte[$];
  int         m_ptr;
  bit         auto_mode;
  int         frame_ticks;
  bit         u_busy, u_done;
  int         u_cnt;
  logic       p_busy;
  logic [7:0] p_din;
  logic [N-1:0] p_ack;
  int         start_err = 0, din_err = 0, ack_err = 0;

  task automatic refresh_lane(input int i);
    req[i] = (lane_q[i].size() != 0);
    req_data[8*i +: 8] = (lane_q[i].size() != 0) ? lane_q[i][0] : 8'($urandom);
  endtask

  // Serve order: always the first non-empty queue at or after the pointer.
  task automatic predict();
    logic [7:0] pend [N][$];
    int total, p;
    total = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = lane_q[i];
      total += lane_q[i].size();
    end
    repeat (total) begin
      p = -1;
      for (int k = 0; k < N; k++)
        if (p < 0 && pend[(m_ptr + k) % N].size() != 0) p = (m_ptr + k) % N;
      exp_idx.push_back(p);
      exp_byte.push_back(pend[p].pop_front());
      m_ptr = (p + 1) % N;
    end
  endtask

  // One clock: sample after the edge, run uart/requester models, drive next inputs.
  task automatic step();
    logic st_b, tk_b;
    int lane;
    st_b = tx_start;
    tk_b = tick;
    @(posedge clk); #1;
    if (auto_mode && u_busy && tk_b) begin
      if (u_done) begin u_busy = 0; u_done = 0; end
      else begin u_cnt++; if (u_cnt == frame_ticks) u_done = 1; end
    end
    if (st_b && tk_b) begin
      if (tx_start) start_err++;
      served_idx.push_back(int'(grant_idx));
      served_byte.push_back(tx_din);
      u_busy = 1; u_cnt = 0; u_done = 0;
    end else if (st_b && !tx_start) start_err++;
    if (busy && !p_busy) begin
      if (!tx_start) start_err++;
      req_data[8*int'(grant_idx) +: 8] = 8'($urandom);
    end
    if (busy && p_busy && tx_din !== p_din) din_err++;
    if (ack !== '0) begin
      if (ack !== (4'b0001 << grant_idx) || p_ack !== '0 || !busy) ack_err++;
      lane = -1;
      for (int b = 0; b < N; b++) if (ack[b] && lane < 0) lane = b;
      ack_log.push_back(lane);
      if (lane_q[lane].size() != 0) void'(lane_q[lane].pop_front());
      refresh_lane(lane);
    end
    p_busy = busy; p_din = tx_din; p_ack = ack;
    if (auto_mode) begin
      tick = ($urandom_range(0, 2) == 0);
      tx_done_tick = u_done;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req_data = '0; tick = 1'b0; tx_done_tick = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    served_idx.delete(); served_byte.delete(); ack_log.delete();
    exp_idx.delete(); exp_byte.delete();
    m_ptr = 0; u_busy = 0; u_done = 0; u_cnt = 0; auto_mode = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    p_busy = 1'b0; p_din = '0; p_ack = '0;
  endtask

  task automatic run_drain(input int budget, output bit ok);
    int n;
    n = 0; ok = 0;
    while (n < budget) begin
      step(); n++;
      if (!busy && !u_busy && req == '0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({ack, busy, grant_idx, tx_start, tx_din} !== '0) begin
      fails++; $display("FAIL reset_async: got %h want 0", {ack, busy, grant_idx, tx_start, tx_din});
    end
    do_reset();
    tests++;
    if ({ack, busy, grant_idx, tx_start, tx_din} !== '0) begin
      fails++; $display("FAIL reset_release: got %h want 0", {ack, busy, grant_idx, tx_start, tx_din});
    end
  endtask

  task automatic test_single();
    int n;
    do_reset(); frame_ticks = 160;
    lane_q[2].push_back(8'hA5); refresh_lane(2);
    step();
    tests++;
    if (busy !== 1'b1 || grant_idx !== 2'd2 || tx_start !== 1'b1) begin
      fails++; $display("FAIL single_grant: busy %b idx %0d start %b want 1 2 1", busy, grant_idx, tx_start);
    end
    tests++;
    if (tx_din !== 8'hA5) begin fails++; $display("FAIL single_din: got %h want a5", tx_din); end
    n = 0;
    while (ack == '0 && n < 3000) begin step(); n++; end
    tests++;
    if (ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", ack); end
    step();
    tests++;
    if (ack !== '0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_after_done: ack %b busy %b want 0000 0", ack, busy);
    end
    tests++;
    if (served_byte.size() != 1 || served_byte[0] !== 8'hA5) begin
      fails++; $display("FAIL single_uart_byte: n %0d byte %h want 1 a5", served_byte.size(), served_byte[0]);
    end
  endtask

  task automatic test_all_four();
    bit ok;
    do_reset(); frame_ticks = 12;
    for (int i = 0; i < N; i++) lane_q[i].push_back(8'(8'h10 + i));
    lane_q[0].push_back(8'($urandom));
    lane_q[3].push_back(8'($urandom));
    for (int i = 0; i < N; i++) refresh_lane(i);
    predict();
    run_drain(4000, ok);
    tests++;
    if (!ok || served_idx.size() != exp_idx.size() || ack_log.size() != exp_idx.size()) begin
      fails++; $display("FAIL all4_count: drained %0d served %0d acked %0d want 1 %0d", ok, served_idx.size(), ack_log.size(), exp_idx.size());
    end
    for (int i = 0; i < exp_idx.size(); i++) begin
      tests++;
      if (served_idx[i] !== exp_idx[i] || served_byte[i] !== exp_byte[i] || ack_log[i] !== exp_idx[i]) begin
        fails++; $display("FAIL all4_xfer%0d: lane %0d byte %h ack %0d want lane %0d byte %h", i, served_idx[i], served_byte[i], ack_log[i], exp_idx[i], exp_byte[i]);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset(); frame_ticks = 8;
    for (int j = 0; j < 3; j++) begin
      lane_q[0].push_back(8'($urandom));
      lane_q[1].push_back(8'($urandom));
    end
    refresh_lane(0); refresh_lane(1);
    predict();
    run_drain(4000, ok);
    tests++;
    if (!ok || ack_log.size() != 6) begin
      fails++; $display("FAIL fair_count: drained %0d acked %0d want 1 6", ok, ack_log.size());
    end
    for (int i = 0; i < exp_idx.size(); i++) begin
      tests++;
      if (served_idx[i] !== exp_idx[i] || served_byte[i] !== exp_byte[i] || ack_log[i] !== exp_idx[i]) begin
        fails++; $display("FAIL fair_xfer%0d: lane %0d byte %h ack %0d want lane %0d byte %h", i, served_idx[i], served_byte[i], ack_log[i], exp_idx[i], exp_byte[i]);
      end
    end
  endtask

  task automatic test_done_no_tick();
    do_reset(); auto_mode = 0;
    lane_q[1].push_back(8'h3C); refresh_lane(1);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    tests++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL dn_wait_entry: start %b busy %b want 0 1", tx_start, busy);
    end
    tx_done_tick = 1'b1;
    repeat (10) step();
    tests++;
    if (ack_log.size() != 0 || busy !== 1'b1) begin
      fails++; $display("FAIL dn_no_tick: acks %0d busy %b want 0 1", ack_log.size(), busy);
    end
    tick = 1'b1; step(); tick = 1'b0;
    tests++;
    if (ack !== 4'b0010) begin fails++; $display("FAIL dn_complete: ack %b want 0010", ack); end
    repeat (3) step();
    tick = 1'b1; step(); tick = 1'b0; tx_done_tick = 1'b0;
    repeat (3) step();
    tests++;
    if (ack_log.size() != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL dn_single_ack: acks %0d busy %b want 1 0", ack_log.size(), busy);
    end
    tests++;
    if (served_byte.size() != 1 || served_byte[0] !== 8'h3C) begin
      fails++; $display("FAIL dn_byte: n %0d byte %h want 1 3c", served_byte.size(), served_byte[0]);
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    bit ok;
    do_reset(); frame_ticks = 40;
    lane_q[1].push_back(8'($urandom)); lane_q[3].push_back(8'($urandom));
    refresh_lane(1); refresh_lane(3);
    n = 0;
    while (ack_log.size() < 1 && n < 1000) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (!(busy && !tx_start && ack == '0) && n < 500);
    repeat (5) step();
    tests++;
    if (!(busy && !tx_start) || grant_idx !== 2'd3 || ack_log.size() != 1) begin
      fails++; $display("FAIL mid_setup: busy %b start %b idx %0d acks %0d want 1 0 3 1", busy, tx_start, grant_idx, ack_log.size());
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ack, busy, grant_idx, tx_start, tx_din} !== '0) begin
      fails++; $display("FAIL mid_async_reset: got %h want 0", {ack, busy, grant_idx, tx_start, tx_din});
    end
    do_reset(); frame_ticks = 10;
    lane_q[0].push_back(8'($urandom)); lane_q[2].push_back(8'($urandom));
    refresh_lane(0); refresh_lane(2);
    predict();
    run_drain(3000, ok);
    tests++;
    if (!ok || ack_log.size() != 2) begin
      fails++; $display("FAIL mid_count: drained %0d acked %0d want 1 2", ok, ack_log.size());
    end
    for (int i = 0; i < exp_idx.size(); i++) begin
      tests++;
      if (served_idx[i] !== exp_idx[i] || served_byte[i] !== exp_byte[i] || ack_log[i] !== exp_idx[i]) begin
        fails++; $display("FAIL mid_xfer%0d: lane %0d byte %h ack %0d want lane %0d byte %h", i, served_idx[i], served_byte[i], ack_log[i], exp_idx[i], exp_byte[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      frame_ticks = $urandom_range(4, 16);
      served_idx.delete(); served_byte.delete(); ack_log.delete();
      exp_idx.delete(); exp_byte.delete();
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 3)) lane_q[i].push_back(8'($urandom));
        refresh_lane(i);
      end
      predict();
      run_drain(6000, ok);
      tests++;
      if (!ok || served_idx.size() != exp_idx.size() || ack_log.size() != exp_idx.size()) begin
        fails++; $display("FAIL rand%0d_count: drained %0d served %0d acked %0d want 1 %0d", r, ok, served_idx.size(), ack_log.size(), exp_idx.size());
      end
      for (int i = 0; i < exp_idx.size(); i++) begin
        tests++;
        if (served_idx[i] !== exp_idx[i] || served_byte[i] !== exp_byte[i] || ack_log[i] !== exp_idx[i]) begin
          fails++; $display("FAIL rand%0d_xfer%0d: lane %0d byte %h ack %0d want lane %0d byte %h", r, i, served_idx[i], served_byte[i], ack_log[i], exp_idx[i], exp_byte[i]);
        end
      end
    end
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset(); auto_mode = 0;
    lane_q[1].push_back(8'h5A); lane_q[2].push_back(8'hC3);
    refresh_lane(1); refresh_lane(2);
    step();
    tests++;
    if (grant_idx !== 2'd1) begin fails++; $display("FAIL to_grant: idx %0d want 1", grant_idx); end
    tick = 1'b1; step(); tick = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      if (t == 8) begin
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL to_early: err %b busy %b want 0 1", err, busy);
        end
      end
      tick = 1'b1; step(); tick = 1'b0;
    end
    tests++;
    if (err !== 1'b1 || ack !== '0) begin
      fails++; $display("FAIL to_err: err %b ack %b want 1 0000", err, ack);
    end
    step();
    tests++;
    if (err !== 1'b0 || ack_log.size() != 0) begin
      fails++; $display("FAIL to_err_width: err %b acks %0d want 0 0", err, ack_log.size());
    end
    step();
    tests++;
    if (grant_idx !== 2'd2 || busy !== 1'b1) begin
      fails++; $display("FAIL to_next_grant: idx %0d busy %b want 2 1", grant_idx, busy);
    end
    auto_mode = 1;
  endtask
`endif

  task automatic test_protocol();
    tests++;
    if (start_err != 0) begin fails++; $display("FAIL proto_tx_start: violations %0d want 0", start_err); end
    tests++;
    if (din_err != 0) begin fails++; $display("FAIL proto_tx_din_stable: violations %0d want 0", din_err); end
    tests++;
    if (ack_err != 0) begin fails++; $display("FAIL proto_ack_onehot: violations %0d want 0", ack_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_done_no_tick();
    test_reset_midflight();
    test_random();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx transmitter between N_REQ byte requesters. It grants one requester at a time and latches that requester's byte. It then issues tx_start aligned to the baud tick, holds tx_din stable, waits for transmit completion, and returns a one-cycle ack to the served requester. It sits between client blocks (debug printers, status reporters) and the single uart_tx instance.

Parameters:
N_REQ, 4, number of requesters; legal range 2..16
IDX_W, $clog2(N_REQ), width of grant index (derived; not overridden)
TIMEOUT_TICKS, 320, tick count in WAIT before abort (used only with optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  baud-rate oversampled tick (same strobe as uart_tx)
req  input  N_REQ  per-requester request level
req_data  input  8*N_REQ  byte for requester i at [8i+7:8i]
ack  output  N_REQ  one-hot, one-clk pulse: requester's byte fully transmitted
busy  output  1  high in any state other than IDLE
grant_idx  output  IDX_W  index of the requester currently being served
tx_start  output  1  start strobe to uart_tx
tx_din  output  8  byte to uart_tx; stable from ISSUE entry until DONE
tx_done_tick  input  1  completion flag from uart_tx

Behaviour:
- Reset (rst_n low, async): state=IDLE, ack=0, busy=0, grant_idx=0, tx_start=0, tx_din=0, rr_ptr=0. Reset mid-transfer aborts silently with no ack; uart_tx is reset separately by the system.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req!=0, select the first set bit scanning from rr_ptr upward, wrapping mod N_REQ.
  - On that edge: latch grant_idx and tx_din=req_data[grant]; go ISSUE.
  - Decision latency: 1 clk from req seen.
- ISSUE:
  - tx_start=1.
  - On a clk with tick=1, go WAIT and drop tx_start. The transmitter samples start on that tick.
  - tick and tx_done_tick are ignored except as the ISSUE exit condition.
- WAIT:
  - Completion is tick=1 AND tx_done_tick=1 on the same clk. tx_done_tick without tick is ignored, because the flag is level-wide for one tick period.
  - On completion: go DONE; rr_ptr=(grant_idx+1) mod N_REQ.
- DONE (exactly one clk):
  - ack[grant_idx]=1, all other ack bits 0.
  - No grant is made in this cycle. Next state IDLE.
- Requester contract:
  - Requester holds req until it sees ack.
  - If it has no further byte, it drops req by the edge ending the ack cycle; otherwise it is regranted when round-robin order reaches it.
  - req_data is sampled only at grant, so it may change afterwards.
- Request deasserted after grant: the transfer still completes and ack still pulses.
- Simultaneous requests: strict round-robin. No requester waits more than N_REQ-1 transfers.
- rr_ptr wraps N_REQ-1 -> 0.
- Back-to-back throughput: one byte per (uart frame + 2 to 3 clk plus tick alignment).

Optional Feature:
Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - Adds output port err (1 bit, reset 0) and a tick counter cleared on WAIT entry.
  - If the counter reaches TIMEOUT_TICKS in WAIT without completion, go DONE with err=1 for that clk and ack held all-zero.
  - rr_ptr advances as normal.
  - Counter width is $clog2(TIMEOUT_TICKS+1).
- Undefined: no err port, no counter; WAIT waits indefinitely.

Test Plan:
- Single requester: req=4'b0100, data[2]=8'hA5; uart_tx model completes after 160 ticks -> tx_din=8'hA5 and tx_start high until the first tick; ack=4'b0100 for exactly 1 clk; grant_idx=2; busy drops the cycle after DONE.
- All four requesting, bytes 8'h10..8'h13 -> served in order 0,1,2,3; four ack pulses. Then req[0] and req[3] remain high -> next grants are 0 then 3 (rr_ptr wrapped to 0).
- Starvation/fairness: req[1] held continuously while req[0] re-asserts after every ack -> grants alternate 0,1,0,1; no requester is served twice consecutively while another waits.
- tx_done_tick held high for 10 clks with tick=0, then tick pulses -> exactly one completion; one ack; no double ack.
- rst_n pulsed low during WAIT -> all outputs 0 immediately (async); no ack. After release with req=4'b0001 -> fresh grant of 0.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_TICKS=8, tx_done_tick never asserted -> err pulses 1 clk after the 8th tick in WAIT; ack stays 0; next pending requester is granted.
